// File: rtl/mfp_input_debounce.sv
// Input conditioning for slide switches and pushbuttons: two-flop synchronizer, per-bit
// stability counter, and a one-cycle pulse on each debounced pushbutton press.
module mfp_input_debounce #(
    parameter int N_SW      = 16,
    parameter int N_PB      = 5,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 19
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [N_SW-1:0] raw_sw,
    input  logic [N_PB-1:0] raw_pb,
    output logic [N_SW-1:0] db_sw,
    output logic [N_PB-1:0] db_pb,
    output logic [N_PB-1:0] pb_rise
);

    localparam int N = N_SW + N_PB;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Switches occupy the low bits and pushbuttons the high bits of every per-bit vector.
    logic [N-1:0]     raw;
    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [N-1:0]     out_q;
    logic [N-1:0]     out_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    assign raw = {raw_pb, raw_sw};

    // NOTE: every variable gets a default before the conditional updates, so no latch is inferred.
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (s2[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    out_d[i] = s2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: non-blocking assignments only, so every flop samples values from before the edge.
    // NOTE: the counters are plain flops rather than a RAM, so clearing them in reset is safe.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1      <= '0;
            s2      <= '0;
            out_q   <= '0;
            pb_rise <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1      <= raw;
            s2      <= s1;
            out_q   <= out_d;
            pb_rise <= ~out_q[N-1:N_SW] & out_d[N-1:N_SW];
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_sw = out_q[N_SW-1:0];
    assign db_pb = out_q[N-1:N_SW];

endmodule

// File: tb/tb_mfp_input_debounce.sv
// Directed bench for mfp_input_debounce with a short debounce window; expected outputs are
// queued with the cycle they are due on and compared when that cycle is reached.
module tb_mfp_input_debounce;

    localparam int N_SW      = 16;
    localparam int N_PB      = 5;
    localparam int DB_CYCLES = 4;
    localparam int CNT_W     = 2;

    logic            HCLK;
    logic            HRESETn;
    logic [N_SW-1:0] raw_sw;
    logic [N_PB-1:0] raw_pb;
    logic [N_SW-1:0] db_sw;
    logic [N_PB-1:0] db_pb;
    logic [N_PB-1:0] pb_rise;

    typedef struct {
        int              due;
        string           tag;
        logic [N_SW-1:0] sw;
        logic [N_PB-1:0] pb;
        logic [N_PB-1:0] rise;
    } exp_t;

    exp_t sb[$];
    int   cycle;
    int   total;
    int   bad;

    mfp_input_debounce #(
        .N_SW     (N_SW),
        .N_PB     (N_PB),
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .raw_sw (raw_sw),
        .raw_pb (raw_pb),
        .db_sw  (db_sw),
        .db_pb  (db_pb),
        .pb_rise(pb_rise)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic exp_at(input int dly, input string tag, input logic [N_SW-1:0] sw,
                          input logic [N_PB-1:0] pb, input logic [N_PB-1:0] rise);
        exp_t e;
        e.due  = cycle + dly;
        e.tag  = tag;
        e.sw   = sw;
        e.pb   = pb;
        e.rise = rise;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [N_SW-1:0] sw,
                         input logic [N_PB-1:0] pb, input logic [N_PB-1:0] rise);
        total++;
        assert (db_sw === sw) else begin
            bad++;
            $error("FAIL %s db_sw cycle=%0d got=%h exp=%h", tag, cycle, db_sw, sw);
        end
        total++;
        assert (db_pb === pb) else begin
            bad++;
            $error("FAIL %s db_pb cycle=%0d got=%b exp=%b", tag, cycle, db_pb, pb);
        end
        total++;
        assert (pb_rise === rise) else begin
            bad++;
            $error("FAIL %s pb_rise cycle=%0d got=%b exp=%b", tag, cycle, pb_rise, rise);
        end
    endtask

    task automatic check_due();
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cycle) begin
                check(sb[i].tag, sb[i].sw, sb[i].pb, sb[i].rise);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge HCLK);
            cycle++;
            #1;
            check_due();
        end
    endtask

    initial begin
        logic [8:0] pat;
        int         c;

        total   = 0;
        bad     = 0;
        cycle   = 0;
        HRESETn = 1'b0;
        raw_sw  = '0;
        raw_pb  = '0;

        // Reset, then a clean press of pb[0]
        tick(2);
        exp_at(0, "reset", 16'h0000, 5'b00000, 5'b00000);
        check_due();
        HRESETn = 1'b1;
        raw_pb  = 5'b00001;
        exp_at(5, "press_pre",  16'h0000, 5'b00000, 5'b00000);
        exp_at(6, "press_db",   16'h0000, 5'b00001, 5'b00001);
        exp_at(7, "press_hold", 16'h0000, 5'b00001, 5'b00000);
        exp_at(8, "press_late", 16'h0000, 5'b00001, 5'b00000);
        tick(8);

        // Glitch of DB_CYCLES-1 clocks on sw[3] is rejected
        raw_sw = 16'h0008;
        exp_at(6, "glitch",      16'h0000, 5'b00001, 5'b00000);
        exp_at(8, "glitch_late", 16'h0000, 5'b00001, 5'b00000);
        tick(3);
        raw_sw = 16'h0000;
        tick(7);

        // Held level on sw[3] is accepted
        raw_sw = 16'h0008;
        exp_at(5, "hold_pre", 16'h0000, 5'b00001, 5'b00000);
        exp_at(6, "hold_db",  16'h0008, 5'b00001, 5'b00000);
        tick(7);

        // Pulse of exactly DB_CYCLES clocks on sw[5] is accepted, then released
        raw_sw = 16'h0028;
        exp_at(5,  "pw4_pre",  16'h0008, 5'b00001, 5'b00000);
        exp_at(6,  "pw4_on",   16'h0028, 5'b00001, 5'b00000);
        exp_at(9,  "pw4_keep", 16'h0028, 5'b00001, 5'b00000);
        exp_at(10, "pw4_off",  16'h0008, 5'b00001, 5'b00000);
        tick(4);
        raw_sw = 16'h0008;
        tick(8);

        // Bouncing pb[2]: 1,0,1,1,0 then steady 1s; one rise only
        pat = 9'b111101101;
        c   = cycle;
        for (int k = 1; k <= 14; k++) begin
            exp_at(k, "bounce", 16'h0008,
                   (k >= 11) ? 5'b00101 : 5'b00001,
                   (k == 11) ? 5'b00100 : 5'b00000);
        end
        for (int k = 0; k < 9; k++) begin
            raw_pb = {2'b00, pat[k], 2'b01};
            tick(1);
        end
        tick(6);

        // Release of pb[2] produces no pulse
        raw_pb = 5'b00001;
        for (int k = 1; k <= 8; k++) begin
            exp_at(k, "release", 16'h0008, (k >= 6) ? 5'b00001 : 5'b00101, 5'b00000);
        end
        tick(8);

        // Release pb[0] and press pb[4] together
        raw_pb = 5'b10000;
        exp_at(5, "simul_pre",  16'h0008, 5'b00001, 5'b00000);
        exp_at(6, "simul_db",   16'h0008, 5'b10000, 5'b10000);
        exp_at(7, "simul_hold", 16'h0008, 5'b10000, 5'b00000);
        tick(8);

        // Asynchronous reset while the switch counters sit at 2
        raw_sw = 16'hFFFF;
        tick(4);
        #2;
        HRESETn = 1'b0;
        #1;
        exp_at(0, "rst_async", 16'h0000, 5'b00000, 5'b00000);
        check_due();
        exp_at(1, "rst_held", 16'h0000, 5'b00000, 5'b00000);
        tick(1);
        HRESETn = 1'b1;
        exp_at(5, "rst_pre",   16'h0000, 5'b00000, 5'b00000);
        exp_at(6, "rst_rel",   16'hFFFF, 5'b10000, 5'b10000);
        exp_at(7, "rst_after", 16'hFFFF, 5'b10000, 5'b00000);
        tick(8);

        // Full-width switch change with no intermediate value
        raw_sw = 16'hA5A5;
        exp_at(6, "to_a5a5", 16'hA5A5, 5'b10000, 5'b00000);
        tick(8);
        raw_sw = 16'h5A5A;
        for (int k = 1; k <= 8; k++) begin
            exp_at(k, "to_5a5a", (k >= 6) ? 16'h5A5A : 16'hA5A5, 5'b10000, 5'b00000);
        end
        tick(9);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_left got=%0d entries exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
